// File: rtl/risc_net_pkg.sv
// Definitions shared by the instruction memory path: fetch, memory and loader.
// Holds the default bus widths and the loader state encoding.
package risc_net_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BYTE_WIDTH = 8;
    localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_FINISH  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles BPW stream bytes into one word, first byte in the least significant lane.
// word_full flags the shift that completes a word; the index then wraps to lane 0.
module byte_packer
    import risc_net_pkg::*;
#(
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int BPW        = BYTES_PER_WORD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      shift_en,
    input  logic [BYTE_WIDTH-1:0]     byte_in,
    output logic [BPW*BYTE_WIDTH-1:0] word,
    output logic                      word_full
);

    localparam int               IDX_W    = $clog2(BPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0]          index_q, index_d;
    logic [BPW*BYTE_WIDTH-1:0] word_q, word_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            word_q  <= '0;
        end else begin
            index_q <= index_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        index_d = index_q;
        word_d  = word_q;
        if (clear) begin
            index_d = '0;
            word_d  = '0;
        end else if (shift_en) begin
            for (int k = 0; k < BPW; k++) begin
                if (index_q == IDX_W'(k)) begin
                    word_d[k*BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
                end
            end
            index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
        end
    end

    assign word      = word_q;
    assign word_full = shift_en && (index_q == LAST_IDX);

endmodule

// File: rtl/instruction_loader.sv
// Programs instruction memory from a byte stream: packs bytes little-endian into words
// and writes them at consecutive addresses from BASE_ADDR while holding the memory bus.
module instruction_loader
    import risc_net_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_wn,
    output logic                  mem_rd,
    output logic                  bus_own,
    output logic                  done
);

    localparam int BPW = DATA_WIDTH / BYTE_WIDTH;

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] written_q, written_d;
    logic                  done_q, done_d;
    logic                  clear, shift_en, word_full;

    byte_packer #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .BPW        (BPW)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .shift_en  (shift_en),
        .byte_in   (byte_in),
        .word      (mem_write_data),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LD_IDLE;
            addr_q    <= BASE_ADDR;
            count_q   <= '0;
            written_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            written_q <= written_d;
            done_q    <= done_d;
        end
    end

    // abort outranks both start and the byte handshake in every state
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        written_d = written_q;
        done_d    = done_q;
        clear     = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (start && !abort) begin
                    done_d = 1'b0;
                    clear  = 1'b1;
                    if (word_count != '0) begin
                        count_d   = word_count;
                        addr_d    = BASE_ADDR;
                        written_d = '0;
                        state_d   = LD_COLLECT;
                    end else begin
                        state_d = LD_FINISH;
                    end
                end
            end
            LD_COLLECT: begin
                if (abort) begin
                    clear   = 1'b1;
                    state_d = LD_IDLE;
                end else if (word_full) begin
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                written_d = written_q + 1'b1;
                if (abort) begin
                    clear   = 1'b1;
                    state_d = LD_IDLE;
                end else if (written_q + 1'b1 == count_q) begin
                    state_d = LD_FINISH;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = LD_COLLECT;
                end
            end
            LD_FINISH: begin
                if (!abort) begin
                    done_d = 1'b1;
                end
                state_d = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_comb begin
        byte_ready  = (state_q == LD_COLLECT) && !abort;
        shift_en    = byte_ready && byte_valid;
        bus_own     = (state_q == LD_COLLECT) || (state_q == LD_WRITE);
        mem_wn      = (state_q == LD_WRITE);
        mem_rd      = 1'b0;
        mem_address = addr_q;
        done        = done_q;
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: table of load scenarios plus hand-written
// sequences for abort, reset and timing corners. BASE_ADDR sits near the top to exercise wrap.
module tb_instruction_loader;

    localparam logic [15:0] BASE = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] word_count = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_wn;
    logic        mem_rd;
    logic        bus_own;
    logic        done;

    instruction_loader #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .BYTE_WIDTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .word_count     (word_count),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_wn         (mem_wn),
        .mem_rd         (mem_rd),
        .bus_own        (bus_own),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: models the instruction memory and counts bus-rule breaches.
    logic [15:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] imem [logic [15:0]];
    int          own_cnt = 0;
    int          rd_viol = 0;
    int          ready_viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wn) begin
                log_addr.push_back(mem_address);
                log_data.push_back(mem_write_data);
                imem[mem_address] = mem_write_data;
            end
            if (bus_own) own_cnt++;
            if (mem_rd) rd_viol++;
            if (bus_own && !mem_wn && !abort && !byte_ready) ready_viol++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents b at the current negedge; returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        byte_in = b;
        byte_valid = 1'b1;
        waited = 0;
        while (!byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte: byte_ready stuck at %0d, required 1", byte_ready);
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (!done && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    typedef struct {
        string name;
        int    count;
        int    gap;
        int    boff;
        int    nbytes;
        int    woff;
    } vec_t;

    logic [7:0]  pool [$];
    logic [31:0] exp_word [$];
    logic [15:0] exp_addr [$];
    vec_t        vecs [5];

    initial begin
        int wbase, obase, rbase, ybase;

        pool = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                 8'h13, 8'h81, 8'h20, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00,
                 8'h33, 8'h02, 8'h11, 8'h40, 8'h93, 8'h02, 8'hF0, 8'hFF};
        exp_word = '{32'h12345678, 32'hDEADBEEF,
                     32'h04030201,
                     32'h00000013, 32'h00100093, 32'h00208113, 32'h002081B3,
                     32'h40110233, 32'hFFF00293};
        exp_addr = '{16'hFFFE, 16'hFFFF,
                     16'hFFFE,
                     16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        vecs[0] = '{"basic",    2, 0, 0,  8, 0};
        vecs[1] = '{"stalled",  2, 7, 0,  8, 0};
        vecs[2] = '{"gap1",     1, 1, 8,  4, 2};
        vecs[3] = '{"loopback", 6, 0, 12, 24, 3};
        vecs[4] = '{"zero",     0, 0, 0,  0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_wn", 32'(mem_wn), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_bus_own", 32'(bus_own), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'(BASE));
        check("rst_mem_write_data", mem_write_data, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven loads
        for (int v = 0; v < 5; v++) begin
            wbase = log_addr.size();
            obase = own_cnt;
            rbase = rd_viol;
            ybase = ready_viol;
            do_start(16'(vecs[v].count));
            if (vecs[v].count != 0)
                check({vecs[v].name, "_done_cleared"}, 32'(done), 32'd0);
            for (int b = 0; b < vecs[v].nbytes; b++) begin
                send_byte(pool[vecs[v].boff + b]);
                if (vecs[v].gap > 0) begin
                    byte_valid = 1'b0;
                    repeat (vecs[v].gap) @(negedge clk);
                end
            end
            byte_valid = 1'b0;
            wait_done();
            check({vecs[v].name, "_bus_own_after"}, 32'(bus_own), 32'd0);
            check({vecs[v].name, "_nwrites"}, 32'(log_addr.size() - wbase), 32'(vecs[v].count));
            for (int i = 0; i < vecs[v].count && wbase + i < log_addr.size(); i++) begin
                check({vecs[v].name, "_addr"}, 32'(log_addr[wbase + i]),
                      32'(exp_addr[vecs[v].woff + i]));
                check({vecs[v].name, "_data"}, log_data[wbase + i], exp_word[vecs[v].woff + i]);
            end
            check({vecs[v].name, "_rd_low"}, 32'(rd_viol - rbase), 32'd0);
            check({vecs[v].name, "_ready_in_collect"}, 32'(ready_viol - ybase), 32'd0);
            if (vecs[v].count == 0)
                check("zero_bus_own_never", 32'(own_cnt - obase), 32'd0);
            if (vecs[v].name == "loopback") begin
                for (int pc = 0; pc < 6; pc++) begin
                    logic [15:0] a;
                    a = exp_addr[vecs[v].woff + pc];
                    check("loopback_fetch", imem.exists(a) ? imem[a] : 32'hxxxxxxxx,
                          exp_word[vecs[v].woff + pc]);
                end
            end
            repeat (2) @(negedge clk);
        end

        // Zero count: done rises exactly two cycles after start is presented
        @(negedge clk);
        start = 1'b1;
        word_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_t1_done", 32'(done), 32'd0);
        check("zero_t1_bus_own", 32'(bus_own), 32'd0);
        @(negedge clk);
        check("zero_t2_done", 32'(done), 32'd1);

        // Write latency, then abort landing on the WRITE cycle
        wbase = log_addr.size();
        do_start(16'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        byte_valid = 1'b0;
        check("lat_mem_wn", 32'(mem_wn), 32'd1);
        check("lat_addr", 32'(mem_address), 32'(BASE));
        check("lat_data", mem_write_data, 32'hDDCCBBAA);
        check("lat_byte_ready", 32'(byte_ready), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abw_bus_own", 32'(bus_own), 32'd0);
        check("abw_mem_wn", 32'(mem_wn), 32'd0);
        repeat (6) @(negedge clk);
        check("abw_done", 32'(done), 32'd0);
        check("abw_nwrites", 32'(log_addr.size() - wbase), 32'd1);

        // Abort in the middle of the second word
        wbase = log_addr.size();
        do_start(16'd3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abm_bus_own", 32'(bus_own), 32'd0);
        check("abm_byte_ready", 32'(byte_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("abm_done", 32'(done), 32'd0);
        check("abm_nwrites", 32'(log_addr.size() - wbase), 32'd1);
        if (log_addr.size() > wbase) begin
            check("abm_addr", 32'(log_addr[wbase]), 32'(BASE));
            check("abm_data", log_data[wbase], 32'h44332211);
        end
        wbase = log_addr.size();
        do_start(16'd1);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        byte_valid = 1'b0;
        wait_done();
        check("abm_reload_nwrites", 32'(log_addr.size() - wbase), 32'd1);
        if (log_addr.size() > wbase) begin
            check("abm_reload_addr", 32'(log_addr[wbase]), 32'(BASE));
            check("abm_reload_data", log_data[wbase], 32'h99887766);
        end

        // Asynchronous reset after six bytes
        wbase = log_addr.size();
        do_start(16'd2);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        send_byte(8'hC5);
        send_byte(8'hC6);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rml_mem_wn", 32'(mem_wn), 32'd0);
        check("rml_bus_own", 32'(bus_own), 32'd0);
        check("rml_byte_ready", 32'(byte_ready), 32'd0);
        check("rml_done", 32'(done), 32'd0);
        check("rml_addr", 32'(mem_address), 32'(BASE));
        check("rml_data", mem_write_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rml_nwrites", 32'(log_addr.size() - wbase), 32'd1);
        check("rml_idle_bus_own", 32'(bus_own), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Write-side counterpart of the instruction fetch path. Instruction fetch only reads instruction memory; this block programs it.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instruction words.
- Writes each word into instruction memory through the memory's write_data/address/wn/rd port, at consecutive word addresses starting at BASE_ADDR.
- Holds the memory bus (bus_own) while loading. The top-level mux returns the bus to InstructionFetch when loading is done.

Parameters:
- ADDR_WIDTH, 16, width of the instruction memory word address (same as pc width).
- DATA_WIDTH, 32, instruction word width. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of the input stream symbol.
- BASE_ADDR, 0, word address of the first loaded instruction.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load of word_count words.
- abort  input  1  abandons the load and returns to IDLE.
- word_count  input  ADDR_WIDTH  number of words to load; sampled on start.
- byte_in  input  BYTE_WIDTH  stream data.
- byte_valid  input  1  stream data valid.
- byte_ready  output  1  loader can accept a byte.
- mem_address  output  ADDR_WIDTH  instruction memory address.
- mem_write_data  output  DATA_WIDTH  instruction memory write data.
- mem_wn  output  1  memory write enable, active high, one cycle per word.
- mem_rd  output  1  memory read enable; driven 0 whenever bus_own=1.
- bus_own  output  1  loader owns the memory bus (high in COLLECT and WRITE).
- done  output  1  level: last load completed; cleared by the next start.

Behaviour:
- Reset values: byte_ready=0, mem_wn=0, mem_rd=0, bus_own=0, done=0, mem_address=BASE_ADDR, mem_write_data=0, internal counters=0, state=IDLE.
- FSM states are IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - start=1 with word_count≠0: latch the count, addr←BASE_ADDR, byte index←0, done←0, go to COLLECT.
  - start=1 with word_count=0: go to FINISH.
- COLLECT:
  - byte_ready=1, bus_own=1.
  - A byte is accepted on the rising edge where byte_valid&&byte_ready.
  - Accepted byte k (k=0..3) goes to word bits [8k+7:8k], i.e. first byte = LSB.
  - When byte 3 is accepted, go to WRITE.
  - byte_valid=0 holds state indefinitely; there is no timeout.
- WRITE:
  - Exactly one cycle with mem_wn=1, mem_address=addr, mem_write_data=assembled word; byte_ready=0.
  - Next state: if words written == count, go to FINISH; otherwise addr←addr+1 and go to COLLECT.
- FINISH: one cycle, bus_own=0, done←1, then IDLE. done stays high in IDLE until the next start.
- Latency: a word's write is visible one cycle after its 4th byte is accepted. Sustained throughput is 4 bytes per 5 cycles.
- Address arithmetic is modulo 2^ADDR_WIDTH; addr wraps from all-ones to 0 silently.
- start while not in IDLE: ignored.
- abort (any state except IDLE): synchronous, takes priority over the byte handshake.
  - Next state is IDLE; done stays 0.
  - A partial word is discarded and never written.
  - If abort coincides with WRITE, the current cycle's write still completes.
- abort and start in the same IDLE cycle: abort wins, no load starts.
- mem_rd=0 whenever bus_own=1. When bus_own=0, mem_rd=0 and the top-level mux drives the memory from fetch.
- Asynchronous reset mid-load forces all outputs to their reset values immediately. No write is issued.

Decomposition:
- Shared package (risc_net_pkg) holds:
  - loader state encoding (IDLE=0, COLLECT=1, WRITE=2, FINISH=3);
  - BYTES_PER_WORD = DATA_WIDTH/BYTE_WIDTH;
  - the shared ADDR_WIDTH/DATA_WIDTH defaults used by InstructionFetch and InstructionMemory.
- One natural sub-module, byte_packer: shift/index register that assembles BYTES_PER_WORD bytes into a word. It outputs word and word_full, with inputs clear and shift_en.

Test Plan:
- Basic load: start, word_count=2, bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE with byte_valid continuous. Expect writes 0x12345678 to address 0 and 0xDEADBEEF to address 1, one mem_wn cycle each, then done=1 and bus_own=0.
- Stalled stream: same load with byte_valid low for 7 cycles between every byte. Expect identical writes, no extra mem_wn pulses, and byte_ready high throughout COLLECT.
- Zero count: start with word_count=0. Expect no mem_wn, bus_own never high, done=1 two cycles after start.
- Abort mid-word: word_count=3, send 5 bytes, then assert abort. Expect 1 write only (address 0), state IDLE, done=0. A new start with word_count=1 then loads at address 0.
- Reset mid-load: deassert rst_n after 6 bytes. Expect mem_wn=0, bus_own=0, byte_ready=0 immediately, and no write of the partial word.
- Loopback with fetch: load 6 words via the loader, then drive pc_in 0..5 into InstructionFetch. Expect instruction to equal each loaded word in order.
